midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
//  Consumes the byte stream from the MIDI UART byte reader, parses channel voice messages
//  (running status included), and schedules note-on/off onto a fixed pool of synth voices.
//  Allocation prefers a free voice; when none is free, it steals the least-recently-assigned one.
//  Sits between the MIDI byte reader and the oscillator/envelope voices.
// PARAMETERS
//  NUM_VOICES  4     voice pool size, 2..8
//  CHANNEL     4'd0  MIDI channel to accept (0 = ch1)
//  OMNI        0     1 = accept all channels, ignoring CHANNEL
// PORTS
//  CLOCK_50       in   1        system clock, 50 MHz
//  RESET_N        in   1        reset, asynchronous, active-low
//  byteValid      in   1        one-cycle pulse: byteData holds a new received byte
//  byteData       in   8        received MIDI byte
//  voiceGate      out  NV       per-voice gate, 1 = note held
//  voiceNote      out  NV*7     per-voice note number; voice v at [7v+6:7v]
//  voiceVelocity  out  NV*7     per-voice velocity, same packing as voiceNote
//  voiceTrigger   out  NV       one-cycle pulse when voice v is (re)assigned
//  msgError       out  1        one-cycle pulse: data byte received with no running status
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0. Parser in IDLE, running status cleared.
//   - LRU rank[v]=v, so voice 0 is oldest. Any partial message is discarded.
//  Parser FSM, evaluated only on byteValid:
//   - IDLE / WAIT_D1 / WAIT_D2 / SKIP1 / SKIP2.
//  Byte classification:
//   - 0xF8-0xFF: realtime. Ignored; FSM and running status unchanged.
//   - 0xF0-0xF7: clear running status, go to IDLE. Later data bytes raise msgError until a new status arrives.
//   - 0x80-0xEF: status byte, which becomes the running status.
//     - Type 8, 9 or B on an accepted channel -> WAIT_D1.
//     - Type C or D -> SKIP1. All other cases -> SKIP2.
//   - Data byte in IDLE: msgError pulses; byte discarded.
//   - Data byte otherwise: WAIT_D1 -> WAIT_D2 (D1 latched). SKIP2 -> SKIP1.
//     - SKIP1 returns to the running-status start state: SKIP1 or SKIP2 for ignored status, WAIT_D1 for accepted.
//     - WAIT_D2 completes the message and returns to WAIT_D1 (running status).
//  Message apply:
//   - Registered on the cycle after the completing byteValid.
//   - Voice outputs and voiceTrigger change on the following edge: latency 2 clocks from byteValid.
//   - The parser keeps accepting bytes during apply; no backpressure is needed (bytes arrive >=320 clocks apart).
//  Note-on (9n, vel>0):
//   - If a gated voice already holds the note, retrigger it: update velocity, pulse trigger.
//   - Else take the lowest-index voice with gate=0.
//   - Else steal the voice with rank 0.
//   - The chosen voice gets gate=1, note, velocity, trigger pulse.
//  Note-off (8n, or 9n with vel=0):
//   - Every gated voice holding that note goes to gate=0. Note and velocity are retained for release.
//   - Unmatched note-off: no effect, no error.
//  CC 123 (Bn 7B xx): all gates 0, no triggers. Other CCs are ignored.
//  LRU ranks:
//   - Ranks form a permutation 0..NV-1. The assigned voice gets rank NV-1.
//   - Voices with rank > its old rank decrement. A retrigger also refreshes the rank.
//  Only one voice changes per note-on. voiceTrigger is never high for two consecutive cycles on the same voice.
// STRUCTURE
//  Shared package midi_defs:
//   - status nibbles (NOTE_OFF=8, NOTE_ON=9, CC=B, PROG=C, CHPRESS=D)
//   - CC_ALL_NOTES_OFF=7'd123, MIDI_DATA_W=7, realtime/system thresholds
//  Sub-module midi_msg_parser (byte -> msgValid/msgType/msgD1/msgD2).
//  Allocator, LRU ranks and voice registers live in this module.
// TESTING
//  - Reset, then 90 3C 64 -> voice0 gate=1 note=60 vel=100, trigger[0] pulses 2 clocks after the last byteValid.
//  - Running status: 90 3C 64, 3E 50, 40 20 -> voices 0,1,2 = notes 60,62,64; a following 3C 00 clears gate[0] only.
//  - Five note-ons 60,62,64,65,67 with NV=4 -> note 67 steals voice0 (oldest); trigger[0] pulses; the others are unchanged.
//  - Interleaving: 90 3C F8 64 (realtime inside message) -> same as 90 3C 64; C0 05 3C 64 -> no voice change.
//  - Errors: a data byte 3C straight after reset, or after F0 -> msgError pulse, no voice change. B0 7B 00 clears all gates.
//  - Async reset mid-message: after 90 3C assert RESET_N=0, then send 64 -> outputs 0 and msgError pulses.

Source files
------------

// File: rtl/midi_defs.sv
// Shared MIDI definitions: status nibbles, data width, byte-class thresholds
// and the parser state encoding.
package midi_defs;

    localparam int          MIDI_DATA_W      = 7;

    localparam logic [3:0]  ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0]  ST_NOTE_ON       = 4'h9;
    localparam logic [3:0]  ST_CC            = 4'hB;
    localparam logic [3:0]  ST_PROG          = 4'hC;
    localparam logic [3:0]  ST_CHPRESS       = 4'hD;

    localparam logic [MIDI_DATA_W-1:0] CC_ALL_NOTES_OFF = 7'd123;

    // Bytes at or above RT_MIN are realtime; SYS_MIN..RT_MIN-1 are system common/exclusive
    localparam logic [7:0]  RT_MIN           = 8'hF8;
    localparam logic [7:0]  SYS_MIN          = 8'hF0;

    typedef enum logic [2:0] {
        P_IDLE    = 3'd0,
        P_WAIT_D1 = 3'd1,
        P_WAIT_D2 = 3'd2,
        P_SKIP1   = 3'd3,
        P_SKIP2   = 3'd4
    } parse_state_e;

endpackage

// File: rtl/midi_msg_parser.sv
// Turns the received MIDI byte stream into complete channel voice messages.
// Running status is kept as the state a data byte restarts from (P_IDLE = none).
module midi_msg_parser
    import midi_defs::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   msg_valid,
    output logic [3:0]             msg_type,
    output logic [MIDI_DATA_W-1:0] msg_d1,
    output logic [MIDI_DATA_W-1:0] msg_d2,
    output logic                   msg_error
);

    parse_state_e           state_q, state_d;
    parse_state_e           rs_start_q, rs_start_d;
    parse_state_e           start_s;
    logic [3:0]             rs_type_q, rs_type_d;
    logic [MIDI_DATA_W-1:0] d1_q, d1_d;
    logic                   msg_valid_q, msg_valid_d;
    logic [3:0]             msg_type_q, msg_type_d;
    logic [MIDI_DATA_W-1:0] msg_d1_q, msg_d1_d;
    logic [MIDI_DATA_W-1:0] msg_d2_q, msg_d2_d;
    logic                   msg_error_q, msg_error_d;
    logic                   chan_ok_s;

    // Start state implied by the incoming byte if it is a status byte
    always_comb begin
        chan_ok_s = OMNI || (byte_data[3:0] == CHANNEL);
        case (byte_data[7:4])
            ST_NOTE_OFF, ST_NOTE_ON, ST_CC: start_s = chan_ok_s ? P_WAIT_D1 : P_SKIP2;
            ST_PROG, ST_CHPRESS:            start_s = P_SKIP1;
            default:                        start_s = P_SKIP2;
        endcase
    end

    // Next-state and message output logic, advanced only on byte_valid
    always_comb begin
        state_d     = state_q;
        rs_start_d  = rs_start_q;
        rs_type_d   = rs_type_q;
        d1_d        = d1_q;
        msg_valid_d = 1'b0;
        msg_type_d  = msg_type_q;
        msg_d1_d    = msg_d1_q;
        msg_d2_d    = msg_d2_q;
        msg_error_d = 1'b0;
        if (!byte_valid) begin
            state_d = state_q;
        end else if (byte_data >= RT_MIN) begin
            state_d = state_q;
        end else if (byte_data >= SYS_MIN) begin
            state_d    = P_IDLE;
            rs_start_d = P_IDLE;
        end else if (byte_data[7]) begin
            rs_type_d  = byte_data[7:4];
            rs_start_d = start_s;
            state_d    = start_s;
        end else begin
            case (state_q)
                P_IDLE:    msg_error_d = 1'b1;
                P_WAIT_D1: begin
                    d1_d    = byte_data[MIDI_DATA_W-1:0];
                    state_d = P_WAIT_D2;
                end
                P_WAIT_D2: begin
                    msg_valid_d = 1'b1;
                    msg_type_d  = rs_type_q;
                    msg_d1_d    = d1_q;
                    msg_d2_d    = byte_data[MIDI_DATA_W-1:0];
                    state_d     = P_WAIT_D1;
                end
                P_SKIP2:   state_d = P_SKIP1;
                P_SKIP1:   state_d = rs_start_q;
                default:   state_d = P_IDLE;
            endcase
        end
    end

    // Parser state and registered message outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= P_IDLE;
            rs_start_q  <= P_IDLE;
            rs_type_q   <= 4'd0;
            d1_q        <= 7'd0;
            msg_valid_q <= 1'b0;
            msg_type_q  <= 4'd0;
            msg_d1_q    <= 7'd0;
            msg_d2_q    <= 7'd0;
            msg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_start_q  <= rs_start_d;
            rs_type_q   <= rs_type_d;
            d1_q        <= d1_d;
            msg_valid_q <= msg_valid_d;
            msg_type_q  <= msg_type_d;
            msg_d1_q    <= msg_d1_d;
            msg_d2_q    <= msg_d2_d;
            msg_error_q <= msg_error_d;
        end
    end

    assign msg_valid = msg_valid_q;
    assign msg_type  = msg_type_q;
    assign msg_d1    = msg_d1_q;
    assign msg_d2    = msg_d2_q;
    assign msg_error = msg_error_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// Schedules parsed note-on/off messages onto a pool of voices. A free voice
// is preferred; otherwise the least-recently-assigned voice (rank 0) is stolen.
module midi_voice_allocator
    import midi_defs::*;
#(
    parameter int         NUM_VOICES = 4,
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter bit         OMNI       = 1'b0
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    byteValid,
    input  logic [7:0]              byteData,
    output logic [NUM_VOICES-1:0]   voiceGate,
    output logic [NUM_VOICES*7-1:0] voiceNote,
    output logic [NUM_VOICES*7-1:0] voiceVelocity,
    output logic [NUM_VOICES-1:0]   voiceTrigger,
    output logic                    msgError
);

    localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                   msg_valid_s;
    logic [3:0]             msg_type_s;
    logic [MIDI_DATA_W-1:0] msg_d1_s, msg_d2_s;

    logic [NUM_VOICES-1:0]  gate_q, gate_d;
    logic [NUM_VOICES-1:0]  trig_q, trig_d;
    logic [MIDI_DATA_W-1:0] note_q [NUM_VOICES];
    logic [MIDI_DATA_W-1:0] note_d [NUM_VOICES];
    logic [MIDI_DATA_W-1:0] vel_q  [NUM_VOICES];
    logic [MIDI_DATA_W-1:0] vel_d  [NUM_VOICES];
    logic [RW-1:0]          rank_q [NUM_VOICES];
    logic [RW-1:0]          rank_d [NUM_VOICES];

    logic                   is_on_s, is_off_s, is_ano_s;
    logic                   hit_found_s, free_found_s;
    logic [RW-1:0]          hit_idx_s, free_idx_s, lru_idx_s, chosen_s, old_rank_s;

    midi_msg_parser #(
        .CHANNEL (CHANNEL),
        .OMNI    (OMNI)
    ) u_parser (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .byte_valid (byteValid),
        .byte_data  (byteData),
        .msg_valid  (msg_valid_s),
        .msg_type   (msg_type_s),
        .msg_d1     (msg_d1_s),
        .msg_d2     (msg_d2_s),
        .msg_error  (msgError)
    );

    // Decode the message and pick the target voice (held note, lowest free, or oldest)
    always_comb begin
        is_on_s  = msg_valid_s && (msg_type_s == ST_NOTE_ON) && (msg_d2_s != 7'd0);
        is_off_s = msg_valid_s && ((msg_type_s == ST_NOTE_OFF) ||
                                   ((msg_type_s == ST_NOTE_ON) && (msg_d2_s == 7'd0)));
        is_ano_s = msg_valid_s && (msg_type_s == ST_CC) && (msg_d1_s == CC_ALL_NOTES_OFF);
        hit_found_s  = 1'b0;
        hit_idx_s    = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        lru_idx_s    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && (note_q[v] == msg_d1_s)) begin
                hit_found_s = 1'b1;
                hit_idx_s   = RW'(v);
            end else begin
                hit_found_s = hit_found_s;
            end
            if (!gate_q[v]) begin
                free_found_s = 1'b1;
                free_idx_s   = RW'(v);
            end else begin
                free_found_s = free_found_s;
            end
            if (rank_q[v] == '0) begin
                lru_idx_s = RW'(v);
            end else begin
                lru_idx_s = lru_idx_s;
            end
        end
        if (hit_found_s) begin
            chosen_s = hit_idx_s;
        end else if (free_found_s) begin
            chosen_s = free_idx_s;
        end else begin
            chosen_s = lru_idx_s;
        end
        old_rank_s = rank_q[chosen_s];
    end

    // Apply the decoded message to the voice registers and LRU ranks
    always_comb begin
        gate_d = gate_q;
        trig_d = '0;
        note_d = note_q;
        vel_d  = vel_q;
        rank_d = rank_q;
        if (is_on_s) begin
            for (int u = 0; u < NUM_VOICES; u++) begin
                if (rank_q[u] > old_rank_s) begin
                    rank_d[u] = rank_q[u] - RW'(1);
                end else begin
                    rank_d[u] = rank_q[u];
                end
            end
            rank_d[chosen_s] = RW'(NUM_VOICES - 1);
            gate_d[chosen_s] = 1'b1;
            trig_d[chosen_s] = 1'b1;
            note_d[chosen_s] = msg_d1_s;
            vel_d[chosen_s]  = msg_d2_s;
        end else if (is_off_s) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (gate_q[v] && (note_q[v] == msg_d1_s)) begin
                    gate_d[v] = 1'b0;
                end else begin
                    gate_d[v] = gate_q[v];
                end
            end
        end else if (is_ano_s) begin
            gate_d = '0;
        end else begin
            gate_d = gate_q;
        end
    end

    // Voice state registers; ranks start as the identity so voice 0 is oldest
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            gate_q <= '0;
            trig_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= 7'd0;
                vel_q[v]  <= 7'd0;
                rank_q[v] <= RW'(v);
            end
        end else begin
            gate_q <= gate_d;
            trig_q <= trig_d;
            note_q <= note_d;
            vel_q  <= vel_d;
            rank_q <= rank_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voiceNote[7*g +: 7]     = note_q[g];
        assign voiceVelocity[7*g +: 7] = vel_q[g];
    end

    assign voiceGate    = gate_q;
    assign voiceTrigger = trig_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus a randomized byte
// stream checked against a message-level model with timestamp-based LRU.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bv = 1'b0;
    logic [7:0]    bd = 8'd0;
    logic [NV-1:0] voiceGate, voiceTrigger;
    logic [NV*7-1:0] voiceNote, voiceVelocity;
    logic          msgError;

    int checks = 0;
    int failures = 0;

    midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .CLOCK_50      (clk),
        .RESET_N       (rst_n),
        .byteValid     (bv),
        .byteData      (bd),
        .voiceGate     (voiceGate),
        .voiceNote     (voiceNote),
        .voiceVelocity (voiceVelocity),
        .voiceTrigger  (voiceTrigger),
        .msgError      (msgError)
    );

    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    int       m_rs;
    int       m_buf[$];
    bit       m_gate[NV];
    int       m_note[NV];
    int       m_vel[NV];
    int       m_stamp[NV];
    int       m_time;
    bit       m_err;
    logic [NV-1:0] m_trig;

    function automatic void model_reset();
        m_rs = -1;
        m_buf.delete();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = i;
        end
        m_time = NV;
        m_err = 1'b0;
        m_trig = '0;
    endfunction

    function automatic void model_msg(int typ, int d1, int d2);
        int v;
        v = -1;
        if (typ == 9 && d2 > 0) begin
            for (int i = 0; i < NV; i++) if (v < 0 && m_gate[i] && m_note[i] == d1) v = i;
            for (int i = 0; i < NV; i++) if (v < 0 && !m_gate[i]) v = i;
            if (v < 0) begin
                v = 0;
                for (int i = 1; i < NV; i++) if (m_stamp[i] < m_stamp[v]) v = i;
            end
            m_gate[v] = 1'b1; m_note[v] = d1; m_vel[v] = d2;
            m_trig[v] = 1'b1;
            m_stamp[v] = m_time;
            m_time++;
        end else if (typ == 8 || typ == 9) begin
            for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == d1) m_gate[i] = 1'b0;
        end else if (typ == 11 && d1 == 123) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
        end
    endfunction

    function automatic void model_byte(int b);
        int typ, need;
        m_err = 1'b0;
        m_trig = '0;
        if (b >= 248) return;
        if (b >= 240) begin m_rs = -1; m_buf.delete(); return; end
        if (b >= 128) begin m_rs = b; m_buf.delete(); return; end
        if (m_rs < 0) begin m_err = 1'b1; return; end
        m_buf.push_back(b);
        typ  = m_rs / 16;
        need = (typ == 12 || typ == 13) ? 1 : 2;
        if (m_buf.size() == need) begin
            if ((m_rs % 16) == 0) model_msg(typ, m_buf[0], (need == 2) ? m_buf[1] : 0);
            m_buf.delete();
        end
    endfunction

    function automatic logic [NV-1:0] m_gate_vec();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = m_gate[i];
        return r;
    endfunction

    function automatic logic [NV*7-1:0] m_note_vec();
        logic [NV*7-1:0] r;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i][6:0];
        return r;
    endfunction

    function automatic logic [NV*7-1:0] m_vel_vec();
        logic [NV*7-1:0] r;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_vel[i][6:0];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    logic          o_err0, o_err1;
    logic [NV-1:0] o_trig0, o_trig1, o_gate;
    logic [NV*7-1:0] o_note, o_vel;

    // Drive one byte; sample one clock after it is taken and again one clock later
    task automatic send_byte(input logic [7:0] b);
        model_byte(int'(b));
        @(negedge clk);
        bv = 1'b1; bd = b;
        @(negedge clk);
        bv = 1'b0;
        o_err0 = msgError; o_trig0 = voiceTrigger;
        @(negedge clk);
        o_err1 = msgError; o_trig1 = voiceTrigger;
        o_gate = voiceGate; o_note = voiceNote; o_vel = voiceVelocity;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({voiceGate, voiceTrigger, msgError} !== 9'd0) begin
            failures++; $display("FAIL reset_ctrl got=%h exp=0", {voiceGate, voiceTrigger, msgError});
        end
        checks++;
        if ({voiceNote, voiceVelocity} !== 56'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {voiceNote, voiceVelocity});
        end
    endtask

    task automatic test_note_on();
        apply_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        checks++;
        if (o_trig0 !== 4'b0000) begin failures++; $display("FAIL trig_early got=%b exp=0000", o_trig0); end
        checks++;
        if (o_trig1 !== 4'b0001) begin failures++; $display("FAIL trig_latency got=%b exp=0001", o_trig1); end
        checks++;
        if (o_gate !== 4'b0001) begin failures++; $display("FAIL note_on_gate got=%b exp=0001", o_gate); end
        checks++;
        if (o_note[6:0] !== 7'd60 || o_vel[6:0] !== 7'd100) begin
            failures++; $display("FAIL note_on_data got=%0d/%0d exp=60/100", o_note[6:0], o_vel[6:0]);
        end
        @(negedge clk);
        checks++;
        if (voiceTrigger !== 4'b0000) begin failures++; $display("FAIL trig_pulse got=%b exp=0000", voiceTrigger); end
    endtask

    task automatic test_running_status();
        apply_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3E); send_byte(8'h50);
        send_byte(8'h40); send_byte(8'h20);
        checks++;
        if (o_gate !== 4'b0111 || o_note !== {7'd0, 7'd64, 7'd62, 7'd60}) begin
            failures++; $display("FAIL running_status got=%b/%h exp=0111/%h", o_gate, o_note, {7'd0, 7'd64, 7'd62, 7'd60});
        end
        send_byte(8'h3C); send_byte(8'h00);
        checks++;
        if (o_gate !== 4'b0110 || o_note[6:0] !== 7'd60 || o_trig1 !== 4'b0000) begin
            failures++; $display("FAIL vel0_off got=%b/%0d/%b exp=0110/60/0000", o_gate, o_note[6:0], o_trig1);
        end
    endtask

    task automatic test_steal();
        apply_reset();
        send_byte(8'h90);
        send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3E); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h64);
        send_byte(8'h41); send_byte(8'h64);
        send_byte(8'h43); send_byte(8'h65);
        checks++;
        if (o_trig1 !== 4'b0001) begin failures++; $display("FAIL steal_trig got=%b exp=0001", o_trig1); end
        checks++;
        if (o_gate !== 4'b1111 || o_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin
            failures++; $display("FAIL steal_notes got=%b/%h exp=1111/%h", o_gate, o_note, {7'd65, 7'd64, 7'd62, 7'd67});
        end
        checks++;
        if (o_vel !== {7'd100, 7'd100, 7'd100, 7'd101}) begin
            failures++; $display("FAIL steal_vel got=%h exp=%h", o_vel, {7'd100, 7'd100, 7'd100, 7'd101});
        end
    endtask

    task automatic test_interleave();
        apply_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        checks++;
        if (o_gate !== 4'b0001 || o_note[6:0] !== 7'd60 || o_trig1 !== 4'b0001) begin
            failures++; $display("FAIL realtime_inside got=%b/%0d/%b exp=0001/60/0001", o_gate, o_note[6:0], o_trig1);
        end
        send_byte(8'hC0); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h64);
        checks++;
        if (o_gate !== 4'b0001 || o_trig1 !== 4'b0000 || o_note[13:7] !== 7'd0 || o_err0 !== 1'b0) begin
            failures++; $display("FAIL prog_change got=%b/%b/%0d/%b exp=0001/0000/0/0", o_gate, o_trig1, o_note[13:7], o_err0);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        send_byte(8'h3C);
        checks++;
        if (o_err0 !== 1'b1 || o_err1 !== 1'b0 || o_gate !== 4'b0000) begin
            failures++; $display("FAIL err_after_reset got=%b%b/%b exp=10/0000", o_err0, o_err1, o_gate);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'hF0); send_byte(8'h3C);
        checks++;
        if (o_err0 !== 1'b1 || o_gate !== 4'b0001 || o_trig1 !== 4'b0000) begin
            failures++; $display("FAIL err_after_sysex got=%b/%b/%b exp=1/0001/0000", o_err0, o_gate, o_trig1);
        end
        send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
        checks++;
        if (o_gate !== 4'b0000 || o_note[6:0] !== 7'd60 || o_trig1 !== 4'b0000 || o_err0 !== 1'b0) begin
            failures++; $display("FAIL all_notes_off got=%b/%0d/%b/%b exp=0000/60/0000/0", o_gate, o_note[6:0], o_trig1, o_err0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        send_byte(8'h90); send_byte(8'h3E); send_byte(8'h64);
        send_byte(8'h3C);
        @(posedge clk);
        #5 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({voiceGate, voiceTrigger, voiceNote, voiceVelocity, msgError} !== '0) begin
            failures++; $display("FAIL async_reset got gate=%b note=%h exp=0", voiceGate, voiceNote);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h64);
        checks++;
        if (o_err0 !== 1'b1 || o_gate !== 4'b0000 || o_trig1 !== 4'b0000) begin
            failures++; $display("FAIL partial_discard got=%b/%b/%b exp=1/0000/0000", o_err0, o_gate, o_trig1);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        logic [7:0] stat_tbl [8];
        stat_tbl[0] = 8'h90; stat_tbl[1] = 8'h90; stat_tbl[2] = 8'h80; stat_tbl[3] = 8'hB0;
        stat_tbl[4] = 8'h91; stat_tbl[5] = 8'hC0; stat_tbl[6] = 8'hD0; stat_tbl[7] = 8'hE0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = stat_tbl[$urandom_range(0, 7)];
            else if (r < 10) b = 8'hF8;
            else if (r < 11) b = 8'hF0;
            else if (r < 70) b = 8'($urandom_range(58, 66));
            else if (r < 80) b = 8'h00;
            else if (r < 84) b = 8'h7B;
            else             b = 8'($urandom_range(0, 127));
            send_byte(b);
            checks++;
            if (o_err0 !== m_err || o_err1 !== 1'b0) begin
                failures++; $display("FAIL rnd_err n=%0d byte=%h got=%b%b exp=%b0", n, b, o_err0, o_err1, m_err);
            end
            checks++;
            if (o_trig0 !== 4'b0000 || o_trig1 !== m_trig) begin
                failures++; $display("FAIL rnd_trig n=%0d byte=%h got=%b/%b exp=0000/%b", n, b, o_trig0, o_trig1, m_trig);
            end
            checks++;
            if (o_gate !== m_gate_vec() || o_note !== m_note_vec() || o_vel !== m_vel_vec()) begin
                failures++; $display("FAIL rnd_voices n=%0d byte=%h got=%b/%h/%h exp=%b/%h/%h",
                                     n, b, o_gate, o_note, o_vel, m_gate_vec(), m_note_vec(), m_vel_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_note_on();
        test_running_status();
        test_steal();
        test_interleave();
        test_errors();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
